// File: rtl/round_robin_arbiter16.sv
// Round-robin arbiter: grants one of N requesters access to a shared resource.
// A grant is released on DONE, on withdrawal of the grantee's request, or
// after MAX_HOLD cycles (EXPIRED pulse), so no requester can starve the rest.
//
// Ports:
//   CLK          rising-edge clock
//   ASYNCRESETN  asynchronous active-low reset
//   REQ[N-1:0]   level requests, held until granted and finished
//   DONE         grantee finished; sampled only while GNT_VALID=1
//   GNT[N-1:0]   one-hot grant, zero when no grant is active
//   GNT_IDX      binary index of the current or last grantee
//   GNT_VALID    a grant is active
//   EXPIRED      one-cycle pulse when a grant is revoked by the timeout
module round_robin_arbiter16 #(
   parameter int unsigned N        = 16,
   parameter int unsigned W        = 4,
   parameter int unsigned MAX_HOLD = 64,
   parameter int unsigned CW       = 6
) (
   input  logic         CLK,
   input  logic         ASYNCRESETN,
   input  logic [N-1:0] REQ,
   input  logic         DONE,
   output logic [N-1:0] GNT,
   output logic [W-1:0] GNT_IDX,
   output logic         GNT_VALID,
   output logic         EXPIRED
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   last_q, last_d;
   logic [W-1:0]   idx_q, idx_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic           valid_q, valid_d;
   logic           expired_q, expired_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   logic [W-1:0]   sel;
   logic [W-1:0]   cand;
   logic           found;
   logic           timeout;
   logic           rel_done;

   // Priority search starting just after the last grantee. Iterating from the
   // farthest offset down lets the nearest requester overwrite the result.
   always_comb begin
      sel   = last_q;
      cand  = last_q;
      found = 1'b0;
      for (int k = int'(N); k >= 1; k--) begin
         cand = last_q + W'(k);
         if (REQ[cand]) begin
            sel   = cand;
            found = 1'b1;
         end
      end
   end

   // Release conditions while busy; DONE and withdrawal outrank the timeout.
   always_comb begin
      timeout  = (MAX_HOLD != 0) && (cnt_q == CW'(MAX_HOLD - 1));
      rel_done = DONE || !REQ[idx_q];
   end

   // Next-state and output logic.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      idx_d     = idx_q;
      gnt_d     = gnt_q;
      valid_d   = valid_q;
      expired_d = 1'b0;
      cnt_d     = cnt_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = BUSY;
               idx_d   = sel;
               valid_d = 1'b1;
               gnt_d   = N'(1) << sel;
               cnt_d   = '0;
            end
         end
         BUSY: begin
            if (rel_done || timeout) begin
               state_d   = IDLE;
               valid_d   = 1'b0;
               gnt_d     = '0;
               last_d    = idx_q;
               expired_d = timeout && !rel_done;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge ASYNCRESETN) begin
      if (!ASYNCRESETN) begin
         state_q   <= IDLE;
         last_q    <= W'(N - 1);
         idx_q     <= '0;
         gnt_q     <= '0;
         valid_q   <= 1'b0;
         expired_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         idx_q     <= idx_d;
         gnt_q     <= gnt_d;
         valid_q   <= valid_d;
         expired_q <= expired_d;
         cnt_q     <= cnt_d;
      end
   end

   assign GNT       = gnt_q;
   assign GNT_IDX   = idx_q;
   assign GNT_VALID = valid_q;
   assign EXPIRED   = expired_q;

endmodule

// File: doc/round_robin_arbiter16.md
Name: round_robin_arbiter16

Overview:
- Arbiter that shares one downstream resource among N requesters (default 16) using round-robin priority.
- Holds a registered grant index and drives a one-hot grant bus, which is the 4-to-16 decode of the index.
- Enforces release on DONE, on request withdrawal, or on a hold-time limit, so no requester can starve the others.
- Sits in front of shared datapath resources (bus, memory port, LUT-based engines) in the mantle library.

Parameters:
- N, 16, number of requesters; power of two, 2..16.
- W, 4, index width = log2(N).
- MAX_HOLD, 64, maximum grant length in cycles; 0 disables the timeout.
- CW, 6, hold-counter width = max(1, ceil(log2(MAX_HOLD))).

Ports:
- CLK  in  1  rising-edge clock.
- ASYNCRESETN  in  1  asynchronous, active-low reset.
- REQ  in  N  per-requester request; level, held until granted and finished.
- DONE  in  1  grantee signals the transaction is complete; sampled only while GNT_VALID=1.
- GNT  out  N  one-hot grant; all zeros when GNT_VALID=0.
- GNT_IDX  out  W  binary index of the current or last grantee.
- GNT_VALID  out  1  a grant is active.
- EXPIRED  out  1  one-cycle pulse when a grant is revoked by the MAX_HOLD timeout.

Behaviour:
- Reset (ASYNCRESETN=0, takes effect immediately regardless of CLK):
  - Outputs: GNT=0, GNT_IDX=0, GNT_VALID=0, EXPIRED=0.
  - Internal: state=IDLE, hold counter=0, priority pointer LAST=N-1, so the first search starts at requester 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, BUSY.
- IDLE:
  - If REQ==0, stay in IDLE; outputs unchanged except EXPIRED=0.
  - Otherwise select the first set bit scanning indices (LAST+1) mod N, (LAST+2) mod N, ..., wrapping around.
  - Next edge: GNT_IDX=selected, GNT_VALID=1, GNT=1<<selected, counter=0, state goes to BUSY.
  - Latency from REQ rising (seen at an edge) to GNT is 1 cycle.
- BUSY: on each edge, evaluate release conditions in this priority order:
  - (a) DONE=1 → release.
  - (b) REQ[GNT_IDX]=0 (withdrawal) → release.
  - (c) MAX_HOLD≠0 and counter==MAX_HOLD-1 → release with EXPIRED=1 for exactly one cycle.
  - If several conditions hold together, (a) or (b) wins and EXPIRED stays 0.
  - Otherwise counter increments, and the grant and outputs are held.
- Release:
  - Next edge: GNT_VALID=0, GNT=0, LAST=GNT_IDX, state goes to IDLE.
  - GNT_IDX keeps the old value.
  - A new grant cannot occur earlier than the following edge, so there is always at least one idle cycle between grants.
  - The released requester has the lowest priority in the next arbitration.
- Changes to REQ bits of non-granted requesters while BUSY have no effect until the next arbitration.
- Counter saturates and never wraps, because release always occurs at MAX_HOLD-1.
- Invariants:
  - GNT has at most one bit set.
  - GNT != 0 if and only if GNT_VALID=1.
  - While GNT_VALID=1, GNT == 1<<GNT_IDX.
- Reset asserted mid-grant drops GNT immediately (asynchronously); after deassertion, arbitration restarts from requester 0.
- DONE while in IDLE is ignored.

Test Plan:
- Reset then REQ=16'h0001 → one cycle later GNT=16'h0001, GNT_IDX=0, GNT_VALID=1. DONE pulse → next cycle GNT=0. Following cycle GNT=16'h0001 again, because REQ[0] is still set.
- REQ=16'hFFFF held, DONE pulsed one cycle after every grant → GNT_IDX sequence is 0,1,2,...,15,0, with exactly one idle cycle between grants; no index is repeated before all 16 are served.
- REQ=16'h8001 with LAST=15 after reset → grant goes to 0. Release → grant goes to 15. Release → grant goes to 0 (wrap-around).
- MAX_HOLD=4, REQ=16'h0010 held, DONE=0 → GNT_VALID is high for exactly 4 cycles, EXPIRED=1 on the cycle GNT drops, then requester 4 is re-granted after one idle cycle.
- Simultaneous DONE and timeout at counter=MAX_HOLD-1 → release occurs with EXPIRED=0. Granted requester drops REQ with DONE=0 → release on the next edge.
- ASYNCRESETN pulsed low mid-grant (not aligned to CLK) → GNT=0 and GNT_VALID=0 immediately. After deassertion with REQ=16'h0006 → grant goes to index 1.
